bus_interface_q: RTL and testbench



---
 rtl/bus_interface_q.sv | 204 ++++++++++++++++++++
 tb/tb_bus_interface_q.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interface_q.sv
// Purpose: queued PE-to-CGRA bus interface; buffers PE commands, issues them via request/grant, returns read data.
// Latency: push->bus_request 2 edges; grant->bus_valid 1 edge; read ack->rsp_valid 2 edges; timeout TIMEOUT+1 after issue.
// Backpressure: cmd_ready drops when the FIFO holds QDEPTH entries; rsp_valid and its fields hold until rsp_ready.
module bus_interface_q #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_AW  = 5,
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_data,
    input  logic [DATA_W-1:0]            cmd_pc,
    input  logic [REG_AW-1:0]            cmd_rs1,
    input  logic [REG_AW-1:0]            cmd_rs2,
    input  logic [REG_AW-1:0]            cmd_rd,
    input  logic                         cmd_reg_sel,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_a,
    output logic [DATA_W-1:0]            rsp_b,
    output logic                         rsp_err,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count,
    output logic                         bus_request,
    input  logic                         grant,
    output logic                         bus_valid,
    output logic [2:0]                   bus_op,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [DATA_W-1:0]            bus_data,
    output logic [DATA_W-1:0]            bus_pc,
    output logic [REG_AW-1:0]            bus_rs1,
    output logic [REG_AW-1:0]            bus_rs2,
    output logic [REG_AW-1:0]            bus_rd,
    output logic                         bus_reg_sel,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_data,
    input  logic                         data_ready,
    input  logic [DATA_W-1:0]            amux_bus,
    input  logic [DATA_W-1:0]            bmux_bus
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);

    localparam logic [2:0] OP_MEM_RD = 3'd0;
    localparam logic [2:0] OP_REG_RD = 3'd3;
    localparam logic [2:0] OP_EXEC   = 3'd4;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_sel;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, REQ, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    cmd_t            fifo_mem [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [15:0]     timer;
    logic            ack_seen;
    cmd_t            head;
    logic            head_illegal;
    logic            push;
    logic            pop;
    logic            ack_hit;

    assign head         = fifo_mem[rd_ptr];
    assign head_illegal = (head.op > OP_EXEC);
    assign cmd_ready    = (count != CW'(QDEPTH));
    assign q_count      = count;
    assign push         = cmd_valid && cmd_ready;
    // Head leaves the queue at the end of its issue cycle, or straight away when it is an illegal op.
    assign pop          = (state == ISSUE) || ((state == IDLE) && (count != '0) && head_illegal);
    // Only the ack that matches the outstanding read type completes it.
    assign ack_hit      = ((bus_op == OP_MEM_RD) && mem_ack) || ((bus_op == OP_REG_RD) && data_ready);

    // Command storage; contents need no reset since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op: cmd_op, addr: cmd_addr, data: cmd_data, pc: cmd_pc,
                                  rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd, reg_sel: cmd_reg_sel};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Issue/response sequencer with all bus and response outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bus_request <= 1'b0;
            bus_valid   <= 1'b0;
            bus_op      <= '0;
            bus_addr    <= '0;
            bus_data    <= '0;
            bus_pc      <= '0;
            bus_rs1     <= '0;
            bus_rs2     <= '0;
            bus_rd      <= '0;
            bus_reg_sel <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_a       <= '0;
            rsp_b       <= '0;
            rsp_err     <= 1'b0;
            timer       <= '0;
            ack_seen    <= 1'b0;
        end else begin
            bus_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        if (head_illegal) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_a     <= '0;
                            rsp_b     <= '0;
                        end else begin
                            state       <= REQ;
                            bus_request <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (grant) begin
                        state       <= ISSUE;
                        bus_request <= 1'b0;
                        bus_valid   <= 1'b1;
                        bus_op      <= head.op;
                        bus_addr    <= head.addr;
                        bus_data    <= head.data;
                        bus_pc      <= head.pc;
                        bus_rs1     <= head.rs1;
                        bus_rs2     <= head.rs2;
                        bus_rd      <= head.rd;
                        bus_reg_sel <= head.reg_sel;
                    end
                end
                ISSUE: begin
                    timer    <= '0;
                    ack_seen <= 1'b0;
                    if ((bus_op == OP_MEM_RD) || (bus_op == OP_REG_RD)) state <= WAIT;
                    else                                              state <= IDLE;
                end
                WAIT: begin
                    // Read data is captured on the ack edge and presented one edge later.
                    if (ack_seen) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else if (ack_hit) begin
                        ack_seen <= 1'b1;
                        rsp_err  <= 1'b0;
                        if (bus_op == OP_MEM_RD) begin
                            rsp_a <= mem_data;
                            rsp_b <= '0;
                        end else begin
                            rsp_a <= amux_bus;
                            rsp_b <= bmux_bus;
                        end
                    end else if (timer == 16'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_a     <= '0;
                        rsp_b     <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_interface_q.sv
// Purpose: directed self-checking bench for bus_interface_q (QDEPTH=4, TIMEOUT=8).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises full-FIFO rejection and rsp_ready stalls.
module tb_bus_interface_q;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data, cmd_pc;
    logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
    logic        cmd_reg_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_a, rsp_b;
    logic [2:0]  q_count;
    logic        bus_request, grant, bus_valid;
    logic [2:0]  bus_op;
    logic [31:0] bus_addr, bus_data, bus_pc;
    logic [4:0]  bus_rs1, bus_rs2, bus_rd;
    logic        bus_reg_sel;
    logic        mem_ack, data_ready;
    logic [31:0] mem_data, amux_bus, bmux_bus;

    int n_checks = 0;
    int n_errors = 0;

    bus_interface_q #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .QDEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_pc(cmd_pc), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_rd(cmd_rd), .cmd_reg_sel(cmd_reg_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rsp_err(rsp_err), .q_count(q_count),
        .bus_request(bus_request), .grant(grant), .bus_valid(bus_valid), .bus_op(bus_op),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_pc(bus_pc), .bus_rs1(bus_rs1),
        .bus_rs2(bus_rs2), .bus_rd(bus_rd), .bus_reg_sel(bus_reg_sel),
        .mem_ack(mem_ack), .mem_data(mem_data), .data_ready(data_ready),
        .amux_bus(amux_bus), .bmux_bus(bmux_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic sel);
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_pc = pc;
        cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_reg_sel = sel;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_bus_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus_valid && n < budget) begin
            tick();
            n++;
        end
        chk(tag, bus_valid, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_bus_request"}, bus_request, 1'b0);
        chk({tag, "_bus_valid"}, bus_valid, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_err"}, rsp_err, 1'b0);
        chk({tag, "_rsp_ab"}, {rsp_a, rsp_b}, 64'h0);
        chk({tag, "_bus_fields"}, {bus_op, bus_addr, bus_data} | {bus_pc, bus_rs1, bus_rs2, bus_rd, bus_reg_sel}, 64'h0);
        chk({tag, "_q_count"}, q_count, 3'd0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    // Expected posted-burst vectors: op, addr, data, pc, rd.
    logic [2:0]  exp_op   [3] = '{3'd1, 3'd2, 3'd4};
    logic [31:0] exp_addr [3] = '{32'h100, 32'h0, 32'h0};
    logic [31:0] exp_data [3] = '{32'hDEADBEEF, 32'h55, 32'hA5A5};
    logic [31:0] exp_pc   [3] = '{32'h1000, 32'h1004, 32'h1008};
    logic [4:0]  exp_rd   [3] = '{5'd0, 5'd5, 5'd0};

    initial begin
        int pulses;
        int first_cyc;
        int last_cyc;
        logic saw_rsp;
        logic saw_req;
        logic [31:0] drain_addr;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_pc = '0;
        cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; cmd_reg_sel = 1'b0; rsp_ready = 1'b0;
        grant = 1'b0; mem_ack = 1'b0; mem_data = '0; data_ready = 1'b0; amux_bus = '0; bmux_bus = '0;
        tick(); tick();
        check_idle_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Posted burst with grant tied high: issues at cycles 2, 5, 8 after the first push.
        grant = 1'b1;
        pulses = 0; first_cyc = -1; last_cyc = -1; saw_rsp = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 3) begin
                cmd_op = exp_op[cyc]; cmd_addr = exp_addr[cyc]; cmd_data = exp_data[cyc];
                cmd_pc = exp_pc[cyc]; cmd_rd = exp_rd[cyc]; cmd_rs1 = '0; cmd_rs2 = '0;
                cmd_reg_sel = 1'b0; cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (rsp_valid) saw_rsp = 1'b1;
            if (bus_valid && pulses < 3) begin
                chk("burst_op", bus_op, exp_op[pulses]);
                chk("burst_addr", bus_addr, exp_addr[pulses]);
                chk("burst_data", bus_data, exp_data[pulses]);
                chk("burst_pc", bus_pc, exp_pc[pulses]);
                chk("burst_rd", bus_rd, exp_rd[pulses]);
                chk("burst_req_low", bus_request, 1'b0);
                if (pulses == 0) chk("burst_first_cycle", cyc, 2);
                else             chk("burst_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                pulses++;
            end else if (bus_valid) begin
                pulses++;
            end
        end
        chk("burst_pulses", pulses, 3);
        chk("burst_no_rsp", saw_rsp, 1'b0);
        chk("burst_q_empty", q_count, 3'd0);
        grant = 1'b0;
        tick();

        // MEM_RD with delayed grant and a stalled response.
        push_cmd(3'd0, 32'h40, 32'h0, 32'h2000, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("rd_qcount_after_push", q_count, 3'd1);
        chk("rd_req_not_yet", bus_request, 1'b0);
        tick();
        chk("rd_req_asserted", bus_request, 1'b1);
        tick(); tick();
        chk("rd_req_held", bus_request, 1'b1);
        chk("rd_no_issue_wo_grant", bus_valid, 1'b0);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("rd_bus_valid", bus_valid, 1'b1);
        chk("rd_req_dropped", bus_request, 1'b0);
        chk("rd_bus_op", bus_op, 3'd0);
        chk("rd_bus_addr", bus_addr, 32'h40);
        chk("rd_bus_pc", bus_pc, 32'h2000);
        tick();
        chk("rd_strobe_one_cycle", bus_valid, 1'b0);
        chk("rd_addr_held", bus_addr, 32'h40);
        chk("rd_popped", q_count, 3'd0);
        mem_ack = 1'b1; mem_data = 32'h12345678;
        tick();
        mem_ack = 1'b0; mem_data = 32'h0;
        chk("rd_rsp_not_yet", rsp_valid, 1'b0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_a", rsp_a, 32'h12345678);
        chk("rd_rsp_b", rsp_b, 32'h0);
        chk("rd_rsp_err", rsp_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd_stall_valid", rsp_valid, 1'b1);
            chk("rd_stall_a", rsp_a, 32'h12345678);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_rsp_released", rsp_valid, 1'b0);

        // REG_RD: a mem_ack in WAIT is ignored, data_ready completes it.
        grant = 1'b1;
        push_cmd(3'd3, 32'h0, 32'h0, 32'h3000, 5'd3, 5'd4, 5'd0, 1'b1);
        wait_bus_valid("rr_issue_seen", 10);
        grant = 1'b0;
        chk("rr_bus_op", bus_op, 3'd3);
        chk("rr_bus_rs", {bus_rs1, bus_rs2, bus_reg_sel}, {5'd3, 5'd4, 1'b1});
        tick();
        mem_ack = 1'b1; mem_data = 32'hBAD;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rr_spurious_ignored", rsp_valid, 1'b0);
        data_ready = 1'b1; amux_bus = 32'd7; bmux_bus = 32'd9;
        tick();
        data_ready = 1'b0; amux_bus = '0; bmux_bus = '0;
        tick();
        chk("rr_rsp_valid", rsp_valid, 1'b1);
        chk("rr_rsp_a", rsp_a, 32'd7);
        chk("rr_rsp_b", rsp_b, 32'd9);
        chk("rr_rsp_err", rsp_err, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Full FIFO: four posted writes held back, fifth rejected.
        for (int i = 0; i < 4; i++) push_cmd(3'd1, 32'h200 + i, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("full_q_count", q_count, 3'd4);
        chk("full_cmd_ready", cmd_ready, 1'b0);
        push_cmd(3'd1, 32'h999, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("full_reject", q_count, 3'd4);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("full_issue_addr", bus_addr, 32'h200);
        tick();
        chk("full_pop_count", q_count, 3'd3);
        chk("full_ready_again", cmd_ready, 1'b1);
        grant = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            tick();
            if (bus_valid) begin
                drain_addr = 32'h201 + pulses;
                chk("drain_addr", bus_addr, drain_addr);
                pulses++;
            end
        end
        grant = 1'b0;
        chk("drain_pulses", pulses, 3);
        chk("drain_empty", q_count, 3'd0);

        // Timeout: MEM_RD with no ack, error exactly 9 edges after the issue strobe.
        grant = 1'b1;
        push_cmd(3'd0, 32'h80, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        wait_bus_valid("to_issue_seen", 10);
        grant = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("to_rsp_valid_timing", rsp_valid, (k == 9));
        end
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_ab", {rsp_a, rsp_b}, 64'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Illegal op 6: error response with no bus request.
        grant = 1'b1;
        push_cmd(3'd6, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        saw_req = bus_request;
        tick();
        chk("ill_rsp_valid", rsp_valid, 1'b1);
        chk("ill_rsp_err", rsp_err, 1'b1);
        chk("ill_popped", q_count, 3'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_request || bus_valid) saw_req = 1'b1;
        end
        chk("ill_no_request", saw_req, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        grant = 1'b0;

        // Reset in the middle of a WAIT with another command queued.
        grant = 1'b1;
        push_cmd(3'd0, 32'hC0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        wait_bus_valid("rst_issue_seen", 10);
        grant = 1'b0;
        push_cmd(3'd2, 32'h0, 32'h77, 32'h0, 5'd0, 5'd0, 5'd1, 1'b0);
        tick();
        reset_n = 1'b0;
        tick(); tick();
        check_idle_outputs("midrst");
        reset_n = 1'b1;
        saw_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_request || rsp_valid) saw_req = 1'b1;
        end
        chk("midrst_stays_idle", saw_req, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
